// File: rtl/uart_ddr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ddr_pkg
//  Description : Shared constants and state encoding for the UART-to-DDR
//                byte-to-word packing datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_ddr_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int WORD_WIDTH     = 128;
  localparam int LANES          = WORD_WIDTH / DATA_WIDTH;
  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  // FILL: assembling bytes; PENDING: closed word waiting for the output slot
  typedef enum logic [0:0] {
    ST_FILL    = 1'b0,
    ST_PENDING = 1'b1
  } pack_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_byte_word_packer_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : packer_addr_gen
//  Description : Target address counter with window wrap, plus the burst
//                counter that decides m_last for each word leaving the packer.
//  Revision    : 1.0 - initial release
// ============================================================================
module packer_addr_gen #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MEM_WORDS      = 64,
  parameter int                    BURST_LEN      = 4,
  parameter int                    BYTES_PER_WORD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,     // a word enters the output register
  input  logic                  partial_i,  // that word was closed by flush
  output logic [ADDR_WIDTH-1:0] addr_o,     // address for the word being loaded
  output logic                  last_o      // m_last for the word being loaded
);

  localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BYTES_PER_WORD);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    BASE_ADDR + ADDR_WIDTH'((MEM_WORDS - 1) * BYTES_PER_WORD);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BC_W-1:0]       bc_q;

  assign addr_o = addr_q;
  assign last_o = (bc_q == BC_W'(BURST_LEN - 1)) || partial_i || (addr_q == LAST_ADDR);

  // Advance address (wrapping at the window end) and burst position per word
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= BASE_ADDR;
      bc_q   <= '0;
    end else if (load_i) begin
      addr_q <= (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + STEP;
      bc_q   <= last_o ? '0 : bc_q + BC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_word_packer
//  Description : Packs a valid/ready byte stream little-endian into wide words
//                with address, lane strobe and burst-last for AXI write issue.
//                A flush pulse closes a partially filled word.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_word_packer #(
  parameter int                    DATA_WIDTH = uart_ddr_pkg::DATA_WIDTH,
  parameter int                    WORD_WIDTH = uart_ddr_pkg::WORD_WIDTH,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = uart_ddr_pkg::DEFAULT_BASE_ADDR,
  parameter int                    MEM_WORDS  = 64,
  parameter int                    BURST_LEN  = 4,
  parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic                               flush,
  output logic [WORD_WIDTH-1:0]              m_word,
  output logic [WORD_WIDTH/DATA_WIDTH-1:0]   m_strb,
  output logic [ADDR_WIDTH-1:0]              m_addr,
  output logic                               m_last,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [15:0]                        words_sent
);

  import uart_ddr_pkg::*;

  localparam int N_LANES    = WORD_WIDTH / DATA_WIDTH;
  localparam int WORD_BYTES = WORD_WIDTH / 8;
  localparam int IDX_W      = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int CNT_W      = IDX_W + 1;

  // Assembly buffer: packed so lane 0 lands in the low byte of the word
  logic [N_LANES-1:0][DATA_WIDTH-1:0] asm_q;
  logic [N_LANES-1:0][DATA_WIDTH-1:0] asm_d;

  pack_state_e            state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       pend_cnt_q;   // lane count of the word parked in PENDING
  logic                   flush_hold_q; // flush seen while PENDING, applied in FILL
  logic                   s_ready_q;

  logic                   m_valid_q;
  logic [WORD_WIDTH-1:0]  m_word_q;
  logic [N_LANES-1:0]     m_strb_q;
  logic [ADDR_WIDTH-1:0]  m_addr_q;
  logic                   m_last_q;
  logic [15:0]            words_sent_q;

  logic                   w_accept;
  logic                   w_handoff;
  logic                   w_slot_free;
  logic                   w_flush_eff;
  logic [CNT_W-1:0]       w_cnt;
  logic                   w_close;
  logic                   w_load;
  logic [CNT_W-1:0]       w_load_cnt;
  logic [N_LANES-1:0]     w_strb;
  logic                   w_partial;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic                   w_last;

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_word     = m_word_q;
  assign m_strb     = m_strb_q;
  assign m_addr     = m_addr_q;
  assign m_last     = m_last_q;
  assign words_sent = words_sent_q;

  // Handshakes, close decision and the contents of the word being loaded
  always_comb begin
    w_accept    = s_valid && s_ready_q;
    w_handoff   = m_valid_q && m_ready;
    w_slot_free = !m_valid_q || m_ready;
    w_flush_eff = flush || flush_hold_q;

    asm_d = asm_q;
    if (w_accept) begin
      asm_d[idx_q] = s_data;
    end

    w_cnt   = CNT_W'(idx_q) + CNT_W'(w_accept);
    w_close = (w_accept && (idx_q == IDX_W'(N_LANES - 1))) ||
              (w_flush_eff && (w_cnt != '0));

    if (state_q == ST_FILL) begin
      w_load     = w_close && w_slot_free;
      w_load_cnt = w_cnt;
    end else begin
      w_load     = w_slot_free;
      w_load_cnt = pend_cnt_q;
    end

    for (int i = 0; i < N_LANES; i++) begin
      w_strb[i] = (CNT_W'(i) < w_load_cnt);
    end
    w_partial = (w_load_cnt != CNT_W'(N_LANES));
  end

  packer_addr_gen #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .BASE_ADDR      (BASE_ADDR),
    .MEM_WORDS      (MEM_WORDS),
    .BURST_LEN      (BURST_LEN),
    .BYTES_PER_WORD (WORD_BYTES)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_load),
    .partial_i (w_partial),
    .addr_o    (w_addr),
    .last_o    (w_last)
  );

  // Packing FSM with its registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      idx_q        <= '0;
      asm_q        <= {N_LANES{PAD_BYTE}};
      pend_cnt_q   <= '0;
      flush_hold_q <= 1'b0;
      s_ready_q    <= 1'b1;
      m_valid_q    <= 1'b0;
      m_word_q     <= '0;
      m_strb_q     <= '0;
      m_addr_q     <= BASE_ADDR;
      m_last_q     <= 1'b0;
      words_sent_q <= '0;
    end else begin
      if (w_handoff) begin
        words_sent_q <= words_sent_q + 16'd1;
      end

      // Output register: load a closed word or empty after handoff
      if (w_load) begin
        m_valid_q <= 1'b1;
        m_word_q  <= asm_d;
        m_strb_q  <= w_strb;
        m_addr_q  <= w_addr;
        m_last_q  <= w_last;
      end else if (w_handoff) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        ST_FILL: begin
          // Any flush is consumed here, whether it closes a word or is a no-op
          flush_hold_q <= 1'b0;
          if (w_close) begin
            idx_q <= '0;
            if (w_slot_free) begin
              asm_q <= {N_LANES{PAD_BYTE}};
            end else begin
              asm_q      <= asm_d;
              pend_cnt_q <= w_cnt;
              state_q    <= ST_PENDING;
              s_ready_q  <= 1'b0;
            end
          end else begin
            asm_q <= asm_d;
            if (w_accept) begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end

        ST_PENDING: begin
          if (flush) begin
            flush_hold_q <= 1'b1;
          end
          if (w_slot_free) begin
            asm_q     <= {N_LANES{PAD_BYTE}};
            idx_q     <= '0;
            state_q   <= ST_FILL;
            s_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_FILL;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_byte_word_packer
//  Description : Directed, table-driven bench for uart_byte_word_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_word_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         flush;
  logic         m_ready;

  logic         s_ready,  s_ready2;
  logic [127:0] m_word,   m_word2;
  logic [15:0]  m_strb,   m_strb2;
  logic [31:0]  m_addr,   m_addr2;
  logic         m_last,   m_last2;
  logic         m_valid,  m_valid2;
  logic [15:0]  words_sent, words_sent2;

  always #5 clk = ~clk;

  uart_byte_word_packer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .flush(flush), .m_word(m_word), .m_strb(m_strb), .m_addr(m_addr),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .words_sent(words_sent)
  );

  // Small address window instance, driven in lockstep with the main one
  uart_byte_word_packer #(.MEM_WORDS(4)) dut_win4 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
    .flush(flush), .m_word(m_word2), .m_strb(m_strb2), .m_addr(m_addr2),
    .m_last(m_last2), .m_valid(m_valid2), .m_ready(m_ready), .words_sent(words_sent2)
  );

  typedef struct packed {
    logic [127:0] word;
    logic [15:0]  strb;
    logic [31:0]  addr;
    logic         last;
  } cap_t;

  typedef struct {
    int           n;
    logic [7:0]   first;
    int           fmode;   // 0 none, 1 flush with last byte, 2 flush pulse after
    logic [127:0] word;
    logic [15:0]  strb;
    logic         last;
  } vec_t;

  cap_t q[$];
  cap_t q2[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every handoff of both instances
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready)
      q.push_back('{word: m_word, strb: m_strb, addr: m_addr, last: m_last});
    if (!rst && m_valid2 && m_ready)
      q2.push_back('{word: m_word2, strb: m_strb2, addr: m_addr2, last: m_last2});
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    q2.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    int   guard;
    logic acc;
    guard = 0;
    acc = 1'b0;
    s_data = b;
    s_valid = 1'b1;
    flush = fl;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
    s_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic wait_n(input int n);
    int g;
    g = 0;
    while (q.size() < n && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (q.size() < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_words: got %0d words expected %0d", q.size(), n);
    end
  endtask

  function automatic logic [127:0] seq_word(input logic [7:0] first);
    logic [127:0] w;
    for (int j = 0; j < 16; j++) w[j*8 +: 8] = first + 8'(j);
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [6];
    logic [127:0] exp_w;
    int           t0;
    logic         stable_ok;

    vecs[0] = '{16, 8'hA0, 0, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 16'hFFFF, 1'b0};
    vecs[1] = '{5,  8'h11, 2, 128'h00000000000000000000001514131211, 16'h001F, 1'b1};
    vecs[2] = '{16, 8'h00, 1, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 1'b0};
    vecs[3] = '{1,  8'h5A, 1, 128'h0000000000000000000000000000005A, 16'h0001, 1'b1};
    vecs[4] = '{15, 8'h01, 2, 128'h000F0E0D0C0B0A090807060504030201, 16'h7FFF, 1'b1};
    vecs[5] = '{8,  8'hC0, 1, 128'h0000000000000000C7C6C5C4C3C2C1C0, 16'h00FF, 1'b1};

    rst = 1'b1;
    s_data = 8'h00;
    s_valid = 1'b0;
    flush = 1'b0;
    m_ready = 1'b1;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_word", m_word, 0);
    chk("rst_m_strb", m_strb, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_words_sent", words_sent, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // Table: single word per vector, each from a fresh reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int j = 0; j < vecs[v].n; j++)
        send_byte(vecs[v].first + 8'(j), (vecs[v].fmode == 1) && (j == vecs[v].n - 1));
      if (vecs[v].fmode == 2) flush_pulse();
      wait_n(1);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", v), q.size(), 1);
      if (q.size() >= 1) begin
        chk($sformatf("vec%0d_word", v), q[0].word, vecs[v].word);
        chk($sformatf("vec%0d_strb", v), q[0].strb, vecs[v].strb);
        chk($sformatf("vec%0d_addr", v), q[0].addr, 0);
        chk($sformatf("vec%0d_last", v), q[0].last, vecs[v].last);
      end
      chk($sformatf("vec%0d_words_sent", v), words_sent, 1);
    end

    // 96 back-to-back bytes -> 6 words, burst boundary on the 4th
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 96; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    chk("b2b_cycles", cyc - t0, 96);
    wait_n(6);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_count", q.size(), 6);
    if (q.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("b2b_word%0d", k), q[k].word, seq_word(8'hA0 + 8'(16 * k)));
        chk($sformatf("b2b_addr%0d", k), q[k].addr, 32'(16 * k));
        chk($sformatf("b2b_last%0d", k), q[k].last, (k == 3));
        chk($sformatf("b2b_strb%0d", k), q[k].strb, 16'hFFFF);
      end
      chk("b2b_word5_const", q[5].word, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    end
    chk("b2b_words_sent", words_sent, 6);

    // Downstream stall with 32 bytes offered
    do_reset();
    m_ready = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
    exp_w = seq_word(8'h00);
    chk("stall_s_ready_low", s_ready, 0);
    chk("stall_m_valid", m_valid, 1);
    stable_ok = 1'b1;
    while (cyc - t0 < 40) begin
      if (m_word !== exp_w || m_addr !== 32'h0 || m_strb !== 16'hFFFF ||
          m_last !== 1'b0 || m_valid !== 1'b1 || s_ready !== 1'b0)
        stable_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("stall_hold_stable", stable_ok, 1);
    chk("stall_no_handoff", q.size(), 0);
    m_ready = 1'b1;
    wait_n(2);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_count", q.size(), 2);
    if (q.size() >= 2) begin
      chk("stall_word0", q[0].word, exp_w);
      chk("stall_addr0", q[0].addr, 32'h00);
      chk("stall_word1", q[1].word, seq_word(8'h10));
      chk("stall_addr1", q[1].addr, 32'h10);
    end
    chk("stall_s_ready_back", s_ready, 1);

    // Flush with empty assembly is a no-op; following data is unaffected
    do_reset();
    flush_pulse();
    repeat (6) @(posedge clk);
    #1;
    chk("flush0_no_word", q.size(), 0);
    chk("flush0_m_valid", m_valid, 0);
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0);
    wait_n(1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush0_next_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("flush0_next_word", q[0].word, seq_word(8'h40));
      chk("flush0_next_strb", q[0].strb, 16'hFFFF);
    end

    // Window wrap with a 4-word window
    do_reset();
    for (int i = 0; i < 80; i++) send_byte(8'(i), 1'b0);
    wait_n(5);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_count", q2.size(), 5);
    if (q2.size() >= 5) begin
      chk("wrap_addr3", q2[3].addr, 32'h30);
      chk("wrap_last3", q2[3].last, 1);
      chk("wrap_last2", q2[2].last, 0);
      chk("wrap_addr4", q2[4].addr, 32'h00);
      chk("wrap_word4", q2[4].word, seq_word(8'h40));
    end
    if (q.size() >= 5) begin
      chk("nowrap_addr4", q[4].addr, 32'h40);
      chk("nowrap_last4", q[4].last, 0);
    end

    // Reset mid-word discards the partial bytes
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(8'h70 + 8'(i), 1'b0);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_m_valid", m_valid, 0);
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i), 1'b0);
    wait_n(1);
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("rstmid_word", q[0].word, seq_word(8'h30));
      chk("rstmid_addr", q[0].addr, 32'h00);
      chk("rstmid_strb", q[0].strb, 16'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
